// File: rtl/dilated_tap_sequencer.sv
// Time-multiplexes one shared 4-lane row x 4x4 matrix multiplier across the K taps of a
// dilated causal convolution layer. Each accepted input row is written into a circular
// history, then K taps are issued one per cycle at dilation offsets; the multiplier results
// are captured a fixed MM_LATENCY cycles after each issue and summed into one output row.
//
// Ports:
//   clk_i, rst_i            clock, asynchronous active-high reset
//   in_row_i/in_v_i/in_rdy_o  input row handshake (ready only while idle)
//   mm_a_o, mm_tap_o        row and weight-matrix select driven to the shared multiplier
//   mm_out0_i..mm_out3_i    multiplier results, 2*W signed
//   out0_o..out3_o          accumulated output row, ACC_W signed
//   out_v_o/out_rdy_i       output row handshake
module dilated_tap_sequencer #(
  parameter int unsigned W           = 16,
  parameter int unsigned K           = 4,
  parameter int unsigned D           = 2,
  parameter int unsigned MM_LATENCY  = 2,
  localparam int unsigned DEPTH      = (K - 1) * D + 1,
  localparam int unsigned ACC_W      = 2 * W + $clog2(K),
  localparam int unsigned TAP_W      = (K > 1) ? $clog2(K) : 1
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic signed [W-1:0]     in_row_i [0:3],
  input  logic                    in_v_i,
  output logic                    in_rdy_o,
  output logic signed [W-1:0]     mm_a_o [0:3],
  output logic [TAP_W-1:0]        mm_tap_o,
  input  logic signed [2*W-1:0]   mm_out0_i,
  input  logic signed [2*W-1:0]   mm_out1_i,
  input  logic signed [2*W-1:0]   mm_out2_i,
  input  logic signed [2*W-1:0]   mm_out3_i,
  output logic signed [ACC_W-1:0] out0_o,
  output logic signed [ACC_W-1:0] out1_o,
  output logic signed [ACC_W-1:0] out2_o,
  output logic signed [ACC_W-1:0] out3_o,
  output logic                    out_v_o,
  input  logic                    out_rdy_i
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  // Capture pipe pattern when only the final tap is still in flight.
  localparam logic [MM_LATENCY-1:0] CapLast = MM_LATENCY'(1) << (MM_LATENCY - 1);

  typedef enum logic [1:0] {StIdle, StIssue, StDrain, StOutput} state_e;

  state_e                  state_q, state_d;
  logic [TAP_W-1:0]        tap_q, tap_d;
  logic [PTR_W-1:0]        wr_ptr_q, wr_ptr_d;
  logic [MM_LATENCY-1:0]   cap_q, cap_d;
  logic signed [ACC_W-1:0] acc_q [4];
  logic signed [ACC_W-1:0] acc_d [4];
  logic signed [W-1:0]     hist_q [DEPTH][4];
  logic                    hist_we;
  logic signed [2*W-1:0]   mm_out [4];
  logic [PTR_W-1:0]        rd_idx;
  logic [31:0]             rd_sum;

  always_comb begin
    mm_out[0] = mm_out0_i;
    mm_out[1] = mm_out1_i;
    mm_out[2] = mm_out2_i;
    mm_out[3] = mm_out3_i;
  end

  // Read index (wr_ptr - k*D) mod DEPTH; DEPTH is added first so the subtraction never
  // goes negative, since k*D <= DEPTH-1.
  always_comb begin
    rd_sum = 32'(wr_ptr_q) + DEPTH - 32'(tap_q) * D;
    if (rd_sum >= DEPTH) rd_sum = rd_sum - DEPTH;
    rd_idx = PTR_W'(rd_sum);
  end

  always_comb begin
    state_d  = state_q;
    tap_d    = tap_q;
    wr_ptr_d = wr_ptr_q;
    hist_we  = 1'b0;
    cap_d    = (cap_q << 1) | MM_LATENCY'(state_q == StIssue);
    for (int j = 0; j < 4; j++) begin
      acc_d[j] = acc_q[j];
      // Results are only meaningful exactly MM_LATENCY edges after an issue.
      if (cap_q[MM_LATENCY-1]) acc_d[j] = acc_q[j] + ACC_W'(mm_out[j]);
    end
    unique case (state_q)
      StIdle: begin
        if (in_v_i) begin
          hist_we = 1'b1;
          tap_d   = '0;
          state_d = StIssue;
          for (int j = 0; j < 4; j++) acc_d[j] = '0;
        end
      end
      StIssue: begin
        if (tap_q == TAP_W'(K - 1)) begin
          tap_d   = '0;
          state_d = StDrain;
        end else begin
          tap_d = tap_q + 1'b1;
        end
      end
      StDrain: begin
        if (cap_q == CapLast) state_d = StOutput;
      end
      StOutput: begin
        if (out_rdy_i) begin
          wr_ptr_d = (wr_ptr_q == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr_q + 1'b1;
          state_d  = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= StIdle;
      tap_q    <= '0;
      wr_ptr_q <= '0;
      cap_q    <= '0;
      for (int j = 0; j < 4; j++) acc_q[j] <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        for (int j = 0; j < 4; j++) hist_q[i][j] <= '0;
      end
    end else begin
      state_q  <= state_d;
      tap_q    <= tap_d;
      wr_ptr_q <= wr_ptr_d;
      cap_q    <= cap_d;
      for (int j = 0; j < 4; j++) acc_q[j] <= acc_d[j];
      if (hist_we) begin
        for (int j = 0; j < 4; j++) hist_q[wr_ptr_q][j] <= in_row_i[j];
      end
    end
  end

  always_comb begin
    in_rdy_o = (state_q == StIdle);
    out_v_o  = (state_q == StOutput);
    mm_tap_o = '0;
    for (int j = 0; j < 4; j++) mm_a_o[j] = '0;
    if (state_q == StIssue) begin
      mm_tap_o = tap_q;
      for (int j = 0; j < 4; j++) mm_a_o[j] = hist_q[rd_idx][j];
    end
    out0_o = '0;
    out1_o = '0;
    out2_o = '0;
    out3_o = '0;
    if (state_q == StOutput) begin
      out0_o = acc_q[0];
      out1_o = acc_q[1];
      out2_o = acc_q[2];
      out3_o = acc_q[3];
    end
  end

endmodule

// File: tb/tb_dilated_tap_sequencer.sv
module tb_dilated_tap_sequencer;

  logic               clk;
  logic               rst;
  logic signed [15:0] in_row [0:3];
  logic               in_v, in_rdy, out_v, out_rdy;
  logic signed [15:0] mm_a [0:3];
  logic [1:0]         mm_tap;
  logic signed [31:0] mm_out0, mm_out1, mm_out2, mm_out3;
  logic signed [33:0] out0, out1, out2, out3;

  logic               in_v2, in_rdy2, out_v2;
  logic signed [15:0] mm_a2 [0:3];
  logic [1:0]         mm_tap2;
  logic signed [31:0] mm2_out0, mm2_out1, mm2_out2, mm2_out3;
  logic signed [33:0] o2_0, o2_1, o2_2, o2_3;

  logic signed [15:0] scale;
  logic               garb;
  logic signed [31:0] p1 [2][4];
  logic signed [31:0] p2 [3][4];
  logic signed [33:0] obs [4];

  int errors = 0;
  int checks = 0;

  dilated_tap_sequencer dut (
    .clk_i(clk), .rst_i(rst), .in_row_i(in_row), .in_v_i(in_v), .in_rdy_o(in_rdy),
    .mm_a_o(mm_a), .mm_tap_o(mm_tap),
    .mm_out0_i(mm_out0), .mm_out1_i(mm_out1), .mm_out2_i(mm_out2), .mm_out3_i(mm_out3),
    .out0_o(out0), .out1_o(out1), .out2_o(out2), .out3_o(out3),
    .out_v_o(out_v), .out_rdy_i(out_rdy)
  );

  dilated_tap_sequencer #(.MM_LATENCY(3)) dut3 (
    .clk_i(clk), .rst_i(rst), .in_row_i(in_row), .in_v_i(in_v2), .in_rdy_o(in_rdy2),
    .mm_a_o(mm_a2), .mm_tap_o(mm_tap2),
    .mm_out0_i(mm2_out0), .mm_out1_i(mm2_out1), .mm_out2_i(mm2_out2), .mm_out3_i(mm2_out3),
    .out0_o(o2_0), .out1_o(o2_1), .out2_o(o2_2), .out3_o(o2_3),
    .out_v_o(out_v2), .out_rdy_i(out_rdy)
  );

  initial clk = 0;
  always #5 clk = ~clk;

  // Multiplier models: mm_out_j = a_j * scale, registered over 2 and 3 cycles.
  always_ff @(posedge clk) begin
    for (int j = 0; j < 4; j++) begin
      p1[0][j] <= mm_a[j] * scale;
      p1[1][j] <= p1[0][j];
      p2[0][j] <= mm_a2[j] * scale;
      p2[1][j] <= p2[0][j];
      p2[2][j] <= p2[1][j];
    end
  end

  always_comb begin
    mm_out0  = p1[1][0];
    mm_out1  = p1[1][1];
    mm_out2  = p1[1][2];
    mm_out3  = p1[1][3];
    mm2_out0 = garb ? 32'sh5A5A5A5A : p2[2][0];
    mm2_out1 = garb ? 32'sh13579BDF : p2[2][1];
    mm2_out2 = garb ? -32'sd77777   : p2[2][2];
    mm2_out3 = garb ? 32'sh7FFFFFFF : p2[2][3];
    obs[0] = out0;
    obs[1] = out1;
    obs[2] = out2;
    obs[3] = out3;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1;
    tick();
    tick();
    rst = 0;
  endtask

  // Waits for in_rdy, accepts one row, waits for out_v; returns the output row and the
  // number of cycles from the accept cycle to the first out_v cycle.
  task automatic run_row(input logic signed [15:0] r [4], output logic signed [33:0] o [4],
                         output int lat);
    int n = 0;
    while (!in_rdy && n < 30) begin tick(); n++; end
    if (!in_rdy) begin
      checks++; errors++;
      $display("FAIL run_row_in_rdy_timeout got=0 exp=1");
    end
    for (int j = 0; j < 4; j++) in_row[j] = r[j];
    in_v = 1;
    tick();
    in_v = 0;
    lat = 1;
    while (!out_v && lat < 30) begin tick(); lat++; end
    if (!out_v) begin
      checks++; errors++;
      $display("FAIL run_row_out_v_timeout got=0 exp=1");
    end
    for (int j = 0; j < 4; j++) o[j] = obs[j];
  endtask

  task automatic test_reset();
    rst = 1;
    tick();
    checks++;
    if (out_v !== 1'b0 || in_rdy !== 1'b1 || mm_tap !== 2'd0) begin
      errors++;
      $display("FAIL reset_ctrl got out_v=%b in_rdy=%b tap=%0d exp 0 1 0", out_v, in_rdy,
               mm_tap);
    end
    for (int j = 0; j < 4; j++) begin
      checks++;
      if (mm_a[j] !== 16'sd0 || obs[j] !== 34'sd0) begin
        errors++;
        $display("FAIL reset_lane%0d got mm_a=%0d out=%0d exp 0 0", j, mm_a[j], obs[j]);
      end
    end
    rst = 0;
  endtask

  task automatic test_single_row();
    logic [1:0] exp_tap;
    do_reset();
    out_rdy = 1;
    in_row = '{16'sd1, 16'sd2, 16'sd3, 16'sd4};
    in_v = 1;
    checks++;
    if (in_rdy !== 1'b1) begin
      errors++; $display("FAIL single_in_rdy got=%b exp=1", in_rdy);
    end
    for (int c = 1; c <= 8; c++) begin
      tick();
      in_v = 0;
      if (c <= 4) begin
        exp_tap = 2'(c - 1);
        checks++;
        if (mm_tap !== exp_tap) begin
          errors++; $display("FAIL single_tap_c%0d got=%0d exp=%0d", c, mm_tap, exp_tap);
        end
        for (int j = 0; j < 4; j++) begin
          checks++;
          if (mm_a[j] !== ((c == 1) ? 16'(j + 1) : 16'sd0)) begin
            errors++;
            $display("FAIL single_mm_a_c%0d_l%0d got=%0d exp=%0d", c, j, mm_a[j],
                     (c == 1) ? j + 1 : 0);
          end
        end
      end
      checks++;
      if (out_v !== (c == 7)) begin
        errors++; $display("FAIL single_out_v_c%0d got=%b exp=%b", c, out_v, c == 7);
      end
      if (c == 7) begin
        for (int j = 0; j < 4; j++) begin
          checks++;
          if (obs[j] !== 34'(j + 1)) begin
            errors++; $display("FAIL single_out_l%0d got=%0d exp=%0d", j, obs[j], j + 1);
          end
        end
      end
      if (c == 8) begin
        checks++;
        if (in_rdy !== 1'b1) begin
          errors++; $display("FAIL single_in_rdy_after got=%b exp=1", in_rdy);
        end
      end
    end
  endtask

  task automatic test_stream_wrap();
    logic signed [15:0] r [4];
    logic signed [33:0] o [4];
    int lat;
    int exp0 [8] = '{1, 2, 4, 6, 9, 12, 16, 20};
    do_reset();
    out_rdy = 1;
    for (int n = 0; n < 8; n++) begin
      r = '{16'(n + 1), 16'sd0, 16'sd0, 16'sd0};
      run_row(r, o, lat);
      checks++;
      if (o[0] !== 34'(exp0[n]) || o[1] !== 34'sd0 || o[2] !== 34'sd0 || o[3] !== 34'sd0
          || lat != 7) begin
        errors++;
        $display("FAIL stream_n%0d got=%0d,%0d,%0d,%0d lat=%0d exp=%0d,0,0,0 lat=7", n,
                 o[0], o[1], o[2], o[3], lat, exp0[n]);
      end
    end
  endtask

  task automatic test_backpressure();
    logic signed [15:0] r [4];
    logic signed [33:0] o [4];
    logic signed [33:0] e [4];
    int lat;
    do_reset();
    out_rdy = 0;
    r = '{16'sd2, -16'sd3, 16'sd4, -16'sd5};
    e = '{34'sd2, -34'sd3, 34'sd4, -34'sd5};
    run_row(r, o, lat);
    checks++;
    if (lat != 7) begin
      errors++; $display("FAIL bp_latency got=%0d exp=7", lat);
    end
    in_row = '{16'sd9, 16'sd9, 16'sd9, 16'sd9};
    for (int i = 0; i < 10; i++) begin
      in_v = (i % 2 == 1);
      tick();
      checks++;
      if (out_v !== 1'b1 || in_rdy !== 1'b0 || obs[0] !== e[0] || obs[1] !== e[1]
          || obs[2] !== e[2] || obs[3] !== e[3]) begin
        errors++;
        $display("FAIL bp_hold_%0d got v=%b rdy=%b out=%0d,%0d,%0d,%0d exp v=1 rdy=0 2,-3,4,-5",
                 i, out_v, in_rdy, obs[0], obs[1], obs[2], obs[3]);
      end
    end
    in_v = 0;
    out_rdy = 1;
    tick();
    checks++;
    if (in_rdy !== 1'b1 || out_v !== 1'b0) begin
      errors++; $display("FAIL bp_release got rdy=%b v=%b exp rdy=1 v=0", in_rdy, out_v);
    end
    // Second zero row reads the slot that held the stalled row; stray writes would show here.
    r = '{16'sd0, 16'sd0, 16'sd0, 16'sd0};
    run_row(r, o, lat);
    run_row(r, o, lat);
    for (int j = 0; j < 4; j++) begin
      checks++;
      if (o[j] !== e[j]) begin
        errors++; $display("FAIL bp_no_write_l%0d got=%0d exp=%0d", j, o[j], e[j]);
      end
    end
  endtask

  task automatic test_full_scale();
    logic signed [15:0] r [4];
    logic signed [33:0] o [4];
    int lat;
    do_reset();
    out_rdy = 1;
    scale = -16'sd32768;
    r = '{-16'sd32768, -16'sd32768, -16'sd32768, -16'sd32768};
    for (int n = 0; n < 7; n++) begin
      run_row(r, o, lat);
      if (n == 2) begin
        checks++;
        if (o[0] !== 34'sh0_8000_0000) begin
          errors++; $display("FAIL full_scale_n2 got=%0d exp=2147483648", o[0]);
        end
      end
    end
    for (int j = 0; j < 4; j++) begin
      checks++;
      if (o[j] !== 34'sh1_0000_0000) begin
        errors++; $display("FAIL full_scale_l%0d got=%0d exp=4294967296", j, o[j]);
      end
    end
    scale = 16'sd1;
  endtask

  task automatic test_reset_mid_issue();
    logic signed [15:0] r [4];
    logic signed [33:0] o [4];
    int lat;
    do_reset();
    out_rdy = 1;
    r = '{16'sd7, 16'sd7, 16'sd7, 16'sd7};
    for (int n = 0; n < 3; n++) run_row(r, o, lat);
    tick();
    in_row = '{16'sd7, 16'sd7, 16'sd7, 16'sd7};
    in_v = 1;
    tick();
    in_v = 0;
    tick();
    checks++;
    if (mm_tap !== 2'd1) begin
      errors++; $display("FAIL mid_pre_tap got=%0d exp=1", mm_tap);
    end
    rst = 1;
    #1;
    checks++;
    if (out_v !== 1'b0 || in_rdy !== 1'b1 || mm_tap !== 2'd0 || mm_a[0] !== 16'sd0
        || mm_a[1] !== 16'sd0 || mm_a[2] !== 16'sd0 || mm_a[3] !== 16'sd0) begin
      errors++;
      $display("FAIL mid_async got v=%b rdy=%b tap=%0d a0=%0d exp v=0 rdy=1 tap=0 a=0",
               out_v, in_rdy, mm_tap, mm_a[0]);
    end
    tick();
    rst = 0;
    r = '{16'sd1, 16'sd2, 16'sd3, 16'sd4};
    run_row(r, o, lat);
    for (int j = 0; j < 4; j++) begin
      checks++;
      if (o[j] !== 34'(j + 1)) begin
        errors++; $display("FAIL mid_after_l%0d got=%0d exp=%0d", j, o[j], j + 1);
      end
    end
  endtask

  task automatic test_capture_alignment();
    do_reset();
    out_rdy = 1;
    garb = 1;
    in_row = '{16'sd5, 16'sd0, 16'sd0, 16'sd0};
    in_v2 = 1;
    checks++;
    if (in_rdy2 !== 1'b1) begin
      errors++; $display("FAIL align_in_rdy got=%b exp=1", in_rdy2);
    end
    for (int c = 1; c <= 8; c++) begin
      tick();
      in_v2 = 0;
      garb = !(c >= 4 && c <= 7);
      checks++;
      if (out_v2 !== (c == 8)) begin
        errors++; $display("FAIL align_out_v_c%0d got=%b exp=%b", c, out_v2, c == 8);
      end
    end
    checks++;
    if (o2_0 !== 34'sd5 || o2_1 !== 34'sd0 || o2_2 !== 34'sd0 || o2_3 !== 34'sd0) begin
      errors++;
      $display("FAIL align_out got=%0d,%0d,%0d,%0d exp=5,0,0,0", o2_0, o2_1, o2_2, o2_3);
    end
    garb = 0;
  endtask

  initial begin
    rst = 1;
    in_v = 0;
    in_v2 = 0;
    out_rdy = 0;
    scale = 16'sd1;
    garb = 0;
    in_row = '{16'sd0, 16'sd0, 16'sd0, 16'sd0};
    test_reset();
    test_single_row();
    test_stream_wrap();
    test_backpressure();
    test_full_scale();
    test_reset_mid_issue();
    test_capture_alignment();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
